instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side companion to the single-cycle core's read-only instruction memory.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Drives the memory write port (WE/A/WD) word by word.
- Holds the core in reset via cpu_rst until the program image is fully loaded.

Parameters:
- MEM_DEPTH, 1024, instruction memory depth in 32-bit words; maximum loadable word count.
- CNT_W, 32, width of the length header and the word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- rx_valid  input  1  byte-source valid.
- rx_data  input  8  byte-source data.
- rx_ready  output  1  loader can accept a byte.
- WE  output  1  instruction memory write enable; one-cycle pulse per word.
- A  output  32  instruction memory byte address; always word aligned, A[1:0]=0.
- WD  output  32  instruction memory write data.
- busy  output  1  high in LEN, DATA and WRITE states.
- done  output  1  high in DONE state.
- err  output  1  high in ERR state.
- cpu_rst  output  1  active-low reset to the core; high only in DONE.
- words_loaded  output  CNT_W  count of words written in the current load.

Behaviour:
- Reset values: state=IDLE; rx_ready=0, WE=0, A=0, WD=0, busy=0, done=0, err=0, cpu_rst=0, words_loaded=0. Internal byte index, length and checksum registers all 0.
- Byte handshake: a byte is accepted on a cycle with rx_valid=1 and rx_ready=1. rx_ready is combinational from state: 1 in LEN and DATA, 0 in all other states.
- States:
  - IDLE: wait for start. On start go to LEN and clear all counters.
  - LEN: accept 4 bytes, little-endian, into the word count N (first byte is N[7:0]). After the 4th byte:
    - N=0 -> DONE (or CSUM if the optional feature is enabled).
    - N>MEM_DEPTH -> ERR.
    - otherwise -> DATA.
  - DATA: accept 4 bytes little-endian into an assembly register. On the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - WE=1, WD=assembled word, A=words_loaded<<2.
    - words_loaded increments at the end of this cycle.
    - If the incremented value equals N -> DONE (or CSUM); else -> DATA.
  - DONE: done=1, cpu_rst=1. Remain until start or reset.
  - ERR: err=1, cpu_rst=0. Remain until start or reset.
- Latency: if the 4th data byte is accepted in cycle k, WE is high in cycle k+1. The next byte can be accepted no earlier than cycle k+2.
- Word k is written at A=4*k. First word at A=0; last word at A=4*(N-1). Maximum address is 4*(MEM_DEPTH-1).
- A and WD hold their last written values outside WRITE. WE is 0 outside WRITE.
- start is ignored while busy=1. In DONE or ERR, start restarts the load: cpu_rst drops to 0 the cycle after start, and words_loaded clears.
- rx_valid with rx_ready=0 is ignored; the byte is not consumed.
- Asynchronous reset mid-load: immediate return to reset values; memory contents already written are undefined to the system.
- Stalls: the source may deassert rx_valid indefinitely. No timeout is applied.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Enabled:
  - After the last WRITE (or after LEN when N=0), enter CSUM and accept one byte with rx_ready=1.
  - The expected value is the XOR of all data bytes (length bytes excluded); N=0 expects 8'h00.
  - Match -> DONE; mismatch -> ERR.
  - The checksum register clears on start.
- Disabled: no CSUM state exists; transitions go directly to DONE. Any byte presented after completion is not accepted (rx_ready=0).

Test Plan:
1. Reset, start, stream 01 00 00 00 03 A3 C4 FF with rx_valid held high -> one WE pulse, A=0, WD=32'hFFC4A303, then done=1, cpu_rst=1, words_loaded=1.
2. N=3 words 00832383, 0064A423, 0062E233, with a 5-cycle rx_valid gap mid-word -> WE at A=0, 4, 8 with matching WD. No WE during the gap. done=1 after the 3rd write.
3. Length header N=1025 (01 04 00 00) -> err=1, cpu_rst=0, no WE. Then start and a valid N=1 stream -> done=1.
4. N=0 -> done=1 with no WE (feature off). With LOADER_CKSUM_EN: byte 00 -> done=1; byte 5A -> err=1.
5. Assert rst low after 6 bytes of a 2-word load -> all outputs at reset values in the same cycle. Restart -> the load completes normally.
6. With LOADER_CKSUM_EN, N=1 data 03 A3 C4 FF: checksum byte 8'h9B -> done=1; 8'h9C -> err=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory write port; holds the core in reset until loaded.
// Define LOADER_CKSUM_EN to require a trailing XOR checksum byte before completion.
module instr_mem_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             WE,
    output logic [31:0]      A,
    output logic [31:0]      WD,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef LOADER_CKSUM_EN
    localparam state_t FIN_ST = S_CSUM;
`else
    localparam state_t FIN_ST = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [1:0]       byte_idx_q;
    logic [31:0]      shift_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] words_q;
    logic [31:0]      a_q;
    logic [31:0]      wd_q;
`ifdef LOADER_CKSUM_EN
    logic [7:0]       cksum_q;
`endif

    logic             acc;
    logic             last_byte;
    logic             restart;
    logic [31:0]      shift_d;
    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] words_inc;

    // Bytes arrive little-endian, so each new byte enters at the top and slides down.
    assign acc       = rx_valid && rx_ready;
    assign last_byte = acc && (byte_idx_q == 2'd3);
    assign shift_d   = {rx_data, shift_q[31:8]};
    assign len_d     = CNT_W'(shift_d);
    assign words_inc = words_q + CNT_W'(1);
    assign restart   = start && (state_q inside {S_IDLE, S_DONE, S_ERR});

    assign A            = a_q;
    assign WD           = wd_q;
    assign words_loaded = words_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        WE       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_LEN;
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && byte_idx_q == 2'd3) begin
                    if (len_d == '0)                      state_d = FIN_ST;
                    else if (len_d > CNT_W'(MEM_DEPTH))   state_d = S_ERR;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                WE      = 1'b1;
                busy    = 1'b1;
                state_d = (words_inc == len_q) ? FIN_ST : S_DATA;
            end
`ifdef LOADER_CKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = (rx_data == cksum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b1;
                if (start) state_d = S_LEN;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            words_q    <= '0;
            a_q        <= '0;
            wd_q       <= '0;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else if (restart) begin
            // A and WD keep the last written word across a restart.
            byte_idx_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            words_q    <= '0;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            if (acc && (state_q inside {S_LEN, S_DATA})) begin
                shift_q    <= shift_d;
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (state_q == S_LEN && last_byte) len_q <= len_d;
            if (state_q == S_DATA && last_byte) begin
                a_q  <= 32'(words_q) << 2;
                wd_q <= shift_d;
            end
`ifdef LOADER_CKSUM_EN
            if (state_q == S_DATA && acc) cksum_q <= cksum_q ^ rx_data;
`endif
            if (state_q == S_WRITE) words_q <= words_inc;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a byte-image reference model.
// Covers the LOADER_CKSUM_EN build as well when that macro is defined.
module tb_instr_mem_loader;
    localparam int MEM_DEPTH = 1024;
    localparam int CNT_W     = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, WE, busy, done, err, cpu_rst;
    logic [31:0] A, WD;
    logic [CNT_W-1:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq[$];
    logic [7:0]  tx_q[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    instr_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .WE(WE), .A(A), .WD(WD), .busy(busy), .done(done),
        .err(err), .cpu_rst(cpu_rst), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (WE) begin
            wr_a.push_back(A);
            wr_d.push_back(WD);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time exceeded, got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_all(input bit hold, input int nwords);
        bit got;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (!hold && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
                if (busy && $urandom_range(0, 3) == 0) pulse_start();
            end
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (rx_ready) begin
                    @(posedge clk); #1;
                    got = 1'b1;
                end
            end
            chk("rx_accept", got, 1);
            if (!got) break;
            if (i >= 4 && i < 4 + 4 * nwords && (i % 4) == 3) begin
                @(negedge clk);
                chk("we_latency", WE, 1);
                chk("write_rx_ready", rx_ready, 0);
            end
            if (!hold) rx_valid = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    // Reference: the image is header(N) then N little-endian words; word k lands at 4*k.
    task automatic run_load(input int n, input bit hold, input bit corrupt);
        logic [31:0] nn;
        logic [7:0]  cks;
        logic [7:0]  b;
        int          nwr_exp;
        bit          exp_err;
        nn = n;
        cks = 8'h00;
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(nn[8*i +: 8]);
        nwr_exp = (n <= MEM_DEPTH) ? n : 0;
        for (int k = 0; k < nwr_exp; k++)
            for (int i = 0; i < 4; i++) begin
                b = wq[k][8*i +: 8];
                tx_q.push_back(b);
                cks ^= b;
            end
        exp_err = (n > MEM_DEPTH);
`ifdef LOADER_CKSUM_EN
        if (!exp_err) begin
            tx_q.push_back(corrupt ? (cks ^ 8'h07) : cks);
            exp_err = corrupt;
        end
`endif
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        chk("start_cpu_rst", cpu_rst, 0);
        chk("start_words", words_loaded, 0);
        chk("start_busy", busy, 1);
        send_all(hold, nwr_exp);
        for (int c = 0; c < 50 && !(done || err); c++) @(negedge clk);
`ifndef LOADER_CKSUM_EN
        if (corrupt) begin
            rx_data  = 8'hA5;
            rx_valid = 1'b1;
            repeat (3) @(negedge clk);
            chk("late_rx_ready", rx_ready, 0);
            rx_valid = 1'b0;
        end
`endif
        chk("done", done, !exp_err);
        chk("err", err, exp_err);
        chk("cpu_rst", cpu_rst, !exp_err);
        chk("busy_end", busy, 0);
        chk("words_loaded", words_loaded, nwr_exp);
        chk("n_writes", wr_a.size(), nwr_exp);
        for (int k = 0; k < wr_a.size() && k < nwr_exp; k++) begin
            chk("wr_addr", wr_a[k], 4 * k);
            chk("wr_data", wr_d[k], wq[k]);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int k = 0; k < n && k <= MEM_DEPTH; k++) wq.push_back($urandom);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {rx_ready, WE, busy, done, err, cpu_rst}, 0);
        chk("rst_A", A, 0);
        chk("rst_WD", WD, 0);
        chk("rst_words", words_loaded, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        wq = '{32'hFFC4A303};
        run_load(1, 1'b1, 1'b0);

        wq = '{32'h00832383, 32'h0064A423, 32'h0062E233};
        run_load(3, 1'b0, 1'b0);

        run_load(1025, 1'b1, 1'b0);
        fill_random(1);
        run_load(1, 1'b0, 1'b0);

        run_load(0, 1'b1, 1'b0);
        run_load(0, 1'b1, 1'b1);

        wq = '{32'hFFC4A303};
        run_load(1, 1'b1, 1'b1);

        // Asynchronous reset after six bytes of a two-word load.
        fill_random(2);
        pulse_start();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, wq[0][7:0], wq[0][15:8]};
        send_all(1'b1, 0);
        #1 rst = 1'b0;
        #1;
        chk("arst_ctrl", {rx_ready, WE, busy, done, err, cpu_rst}, 0);
        chk("arst_A", A, 0);
        chk("arst_WD", WD, 0);
        chk("arst_words", words_loaded, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_load(2, 1'b0, 1'b0);

        fill_random(MEM_DEPTH);
        run_load(MEM_DEPTH, 1'b1, 1'b0);

        for (int it = 0; it < 12; it++) begin
            n = ($urandom_range(0, 9) == 0) ? 1025 + $urandom_range(0, 5000) : $urandom_range(0, 6);
            fill_random(n);
            run_load(n, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
